// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: per-digit time slots split into 16 brightness phases,
// with a staging/shadow register pair so a new load only takes effect at a frame boundary.
module seg7_scan #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [8*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   digit_en,
  input  logic [3:0]        bright,
  input  logic              load,
  output logic              busy,
  output logic              frame_done,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        seg
);

  localparam int unsigned SubMax = DIV / 16;
  localparam int unsigned SubW   = (SubMax > 1) ? $clog2(SubMax) : 1;
  localparam int unsigned IdxW   = $clog2(NDIG);

  logic [SubW-1:0]   sub_q, sub_d;
  logic [3:0]        phase_q, phase_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              sub_tc, tick, wrap;

  logic              stg_mode_q, shd_mode_q;
  logic [8*NDIG-1:0] stg_data_q, shd_data_q;
  logic [NDIG-1:0]   stg_dp_q, shd_dp_q;
  logic [NDIG-1:0]   stg_en_q, shd_en_q;
  logic              busy_q, busy_d;
  logic              frame_done_q;

  logic [7:0]        cur_byte;
  logic              cur_dp, cur_en;
  logic [NDIG-1:0]   an_d;
  logic [7:0]        seg_d;
  logic [NDIG-1:0]   an_q;
  logic [7:0]        seg_q;

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign sub_tc = (sub_q == SubW'(SubMax - 1));
  assign tick   = sub_tc && (phase_q == 4'd15);
  assign wrap   = tick && (idx_q == IdxW'(NDIG - 1));

  always_comb begin
    sub_d   = sub_tc ? '0 : sub_q + SubW'(1);
    phase_d = sub_tc ? phase_q + 4'd1 : phase_q;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + IdxW'(1);
    end
    // A load on the wrap edge re-arms busy for the values it just staged.
    busy_d = busy_q;
    if (wrap) busy_d = 1'b0;
    if (load) busy_d = 1'b1;
  end

  always_comb begin
    cur_byte = '0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    an_d     = '1;
    seg_d    = 8'hFF;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_byte = shd_data_q[8*(NDIG-i)-1 -: 8];
        cur_dp   = shd_dp_q[i];
        cur_en   = shd_en_q[i];
      end
    end
    if (cur_en && (phase_q <= bright)) begin
      for (int i = 0; i < NDIG; i++) begin
        an_d[i] = (idx_q != IdxW'(i));
      end
      seg_d = shd_mode_q ? {~cur_dp, ~hex7(cur_byte[3:0])} : cur_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      stg_mode_q   <= 1'b0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      shd_mode_q   <= 1'b0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      shd_en_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      frame_done_q <= wrap;
      an_q         <= an_d;
      seg_q        <= seg_d;
      if (wrap && busy_q) begin
        shd_mode_q <= stg_mode_q;
        shd_data_q <= stg_data_q;
        shd_dp_q   <= stg_dp_q;
        shd_en_q   <= stg_en_q;
      end
      if (load) begin
        stg_mode_q <= mode;
        stg_data_q <= data;
        stg_dp_q   <= dp;
        stg_en_q   <= digit_en;
      end
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NDIG, default 4, number of digits scanned; legal range 2..8.
REQ-002 Parameter DIV, default 100000, clock cycles per digit slot; SHALL be a multiple of 16 and >= 16.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  1  0 = raw segment bytes, 1 = hex decode of low nibble per digit.
REQ-006 data  input  8*NDIG  one byte per digit; digit i uses data[8*(NDIG-i)-1 -: 8], so digit 0 is the MSB byte.
REQ-007 dp  input  NDIG  decimal point per digit (bit i = digit i), used in hex mode only; 1 = lit.
REQ-008 digit_en  input  NDIG  bit i = 1 enables digit i; 0 blanks it.
REQ-009 bright  input  4  brightness; digit lit for bright+1 of 16 phases per slot.
REQ-010 load  input  1  single-cycle strobe capturing mode/data/dp/digit_en into staging.
REQ-011 busy  output  1  staged values not yet committed to display.
REQ-012 frame_done  output  1  one-cycle pulse at each frame wrap.
REQ-013 an  output  NDIG  digit anodes, active-low; an[i] drives digit i.
REQ-014 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-015 Sub-counter counts 0..DIV/16-1; at terminal count, phase counter (0..15) increments and wraps.
REQ-016 Slot tick = sub-counter terminal AND phase 15; digit index idx increments on tick, wraps NDIG-1 -> 0.
REQ-017 Frame wrap = tick with idx = NDIG-1; frame_done SHALL pulse high the cycle after that edge, for exactly 1 cycle.
REQ-018 load SHALL copy mode, data, dp, digit_en into staging on the load edge and set busy.
REQ-019 At frame wrap with busy set, shadow <= staging and busy clears, on the same edge; display reads only shadow, so no frame mixes old and new data.
REQ-020 load coincident with frame wrap: commit uses prior staging, new values enter staging, busy stays 1.
REQ-021 Repeated load while busy overwrites staging; exactly one commit at the next wrap.
REQ-022 bright is sampled live, not shadowed.
REQ-023 Digit idx lit when shadow digit_en[idx] = 1 and phase <= bright; otherwise an = all ones, seg = 8'hFF.
REQ-024 When lit, an = all ones except bit idx = 0.
REQ-025 Raw mode lit: seg = data byte of idx, unmodified.
REQ-026 Hex mode lit: seg = {~dp[idx], ~F(nibble)}, F active-high gfedcba table 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-027 an and seg are registered; they reflect counter state of the previous cycle (1-cycle latency), never glitch within a cycle.

Reset
REQ-028 rst_n low SHALL immediately force: counters, idx, phase = 0; staging and shadow = 0 (shadow digit_en = 0); busy = 0; frame_done = 0; an = all ones; seg = 8'hFF.
REQ-029 After release, display stays blank until first load commits; scan restarts at digit 0, phase 0.
REQ-030 Reset mid-frame or while busy discards staged data; no commit occurs.

Verification (NDIG=4, DIV=16)
REQ-031 Reset: rst_n low -> an=4'hF, seg=8'hFF, busy=0; after release, no load for 200 cycles -> outputs stay blank.
REQ-032 Hex: mode=1, data=32'h01020A0F, dp=0, digit_en=4'hF, bright=15, load -> after commit, an 1110/1101/1011/0111 with seg F9/A4/88/8E, each held 16 cycles.
REQ-033 Brightness: bright=3 -> each digit lit 4 consecutive cycles (phases 0-3), blank 12; bright=0 -> lit 1 of 16.
REQ-034 Mid-frame load during digit 1 -> busy=1, outputs unchanged until digit 0 of next frame; busy clears on the frame_done cycle.
REQ-035 Raw/enable: mode=0, data=32'h5A5A5A5A, digit_en=4'b0101 -> digits 0 and 2 show seg=8'h5A, digits 1 and 3 blank (an=4'hF, seg=8'hFF).
REQ-036 Async reset asserted mid-slot, between clock edges -> an=4'hF, seg=8'hFF without waiting for a clock edge; after release, digit 0 resumes only after a new load.
